// File: rtl/cmv300_pkg.sv
// Shared types and constants for the CMV300 frame-capture path: FSM states,
// error codes and the sensor geometry.
package cmv300_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT_FV = 3'd2,
    ST_FRAME   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_LINES   = 2'd2,
    ERR_OVF     = 2'd3
  } err_code_e;

  localparam int unsigned CMV300_LINES  = 488;
  localparam int unsigned CMV300_PIXELS = 648;

endpackage

// File: rtl/cdc_sync_edge.sv
// N-stage synchroniser for a single asynchronous level, with registered
// one-cycle rise/fall pulses derived from the synchronised value.
module cdc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_async};
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  // NOTE: sequential state uses <= so every flop samples its pre-edge inputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;

endmodule

// File: rtl/cmv300_frame_seq.sv
// CMV300 frame-capture sequencer: issues FRAME_REQ, tracks FVAL/LVAL, counts
// lines and reports clean completion, timeout, line mismatch or FIFO overflow.
module cmv300_frame_seq
  import cmv300_pkg::*;
#(
  parameter int REQ_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 8000000,
  parameter int EXPECTED_LINES = CMV300_LINES,
  parameter int LINE_W         = 10,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_sensor_ready,
  input  logic              i_fval,
  input  logic              i_lval,
  input  logic              i_fifo_full,
  output logic              o_frame_req,
  output logic              o_fifo_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [LINE_W-1:0] o_line_count
);

  localparam int REQ_W = $clog2(REQ_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic [REQ_W-1:0]  req_cnt_q, req_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              err_q, err_d;
  err_code_e         code_q, code_d;

  logic fval_rise, fval_fall, lval_rise, lval_fall_unused;
  logic tmo_hit;

  cdc_sync_edge #(.STAGES(SYNC_STAGES)) u_fval_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_fval),
    .o_rise  (fval_rise),
    .o_fall  (fval_fall)
  );

  cdc_sync_edge #(.STAGES(SYNC_STAGES)) u_lval_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_lval),
    .o_rise  (lval_rise),
    .o_fall  (lval_fall_unused)
  );

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal gets its hold value first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    tmo_d     = tmo_q;
    line_d    = line_q;
    err_d     = err_q;
    code_d    = code_q;

    // Abort beats everything, including a start in the same IDLE cycle.
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start && i_sensor_ready) begin
            state_d   = ST_REQ;
            req_cnt_d = '0;
            line_d    = '0;
            err_d     = 1'b0;
            code_d    = ERR_NONE;
          end
        end
        ST_REQ: begin
          tmo_d = '0;
          if (req_cnt_q == REQ_W'(REQ_CYCLES - 1)) state_d = ST_WAIT_FV;
          else req_cnt_d = req_cnt_q + 1'b1;
        end
        ST_WAIT_FV: begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_hit) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
          end else if (fval_rise) begin
            state_d = ST_FRAME;
          end
        end
        ST_FRAME: begin
          tmo_d = tmo_q + 1'b1;
          // Count before the end-of-frame test so a coincident last line is seen.
          if (lval_rise && (line_q != '1)) line_d = line_q + 1'b1;
          if (i_fifo_full) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_OVF;
          end else if (tmo_hit) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
          end else if (fval_fall) begin
            if (line_d == LINE_W'(EXPECTED_LINES)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ERR;
              err_d   = 1'b1;
              code_d  = ERR_LINES;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      req_cnt_q <= '0;
      tmo_q     <= '0;
      line_q    <= '0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      tmo_q     <= tmo_d;
      line_q    <= line_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // Decoded straight from the state flop so reset clears them without a clock.
  assign o_frame_req  = (state_q == ST_REQ);
  assign o_fifo_rst   = (state_q == ST_IDLE) || (state_q == ST_ERR);
  assign o_busy       = (state_q == ST_REQ) || (state_q == ST_WAIT_FV) ||
                        (state_q == ST_FRAME);
  assign o_done       = (state_q == ST_DONE);
  assign o_err        = err_q;
  assign o_err_code   = code_q;
  assign o_line_count = line_q;

endmodule

// File: doc/cmv300_frame_seq.md
Name: cmv300_frame_seq

Overview:
Frame-capture sequencer for the CMV300 sensor path, running in the 80 MHz system clock domain. It accepts a capture request from the host, checks the sensor is ready, and drives FRAME_REQ. It then synchronises the sensor's FVAL/LVAL, counts lines, and reports frame completion, timeout or line-count mismatch. This replaces the fixed "done one tick after FRAME_REQ" behaviour with true end-of-frame detection, and it gates host reads of the pixel FIFO.

Parameters:
REQ_CYCLES, 4, i_clk cycles FRAME_REQ is held high (must be >= 2 sensor CLK_IN periods)
TIMEOUT_CYCLES, 8000000, max i_clk cycles from FRAME_REQ release to FVAL falling (100 ms @ 80 MHz)
EXPECTED_LINES, 488, LVAL rising edges required per frame
LINE_W, 10, width of line counter
SYNC_STAGES, 2, flip-flop stages on i_fval/i_lval (min 2)

Ports:
i_clk  in  1  system clock, 80 MHz
i_rst  in  1  asynchronous active-high reset
i_start  in  1  single-cycle capture request
i_abort  in  1  single-cycle abort; returns to IDLE
i_sensor_ready  in  1  sensor power-up/reset sequence complete
i_fval  in  1  sensor FVAL, asynchronous to i_clk
i_lval  in  1  sensor LVAL, asynchronous to i_clk
i_fifo_full  in  1  pixel FIFO overflow flag (already in i_clk domain)
o_frame_req  out  1  FRAME_REQ to sensor
o_fifo_rst  out  1  pixel FIFO reset, held high in IDLE and ERR
o_busy  out  1  capture in progress
o_done  out  1  one-cycle pulse, frame finished cleanly
o_err  out  1  level, sticky until next i_start or reset
o_err_code  out  2  0 none, 1 FVAL timeout, 2 line-count mismatch, 3 FIFO overflow
o_line_count  out  LINE_W  lines seen in current/last frame

Behaviour:
- Reset values (async, immediate): state IDLE, o_frame_req=0, o_fifo_rst=1, o_busy=0, o_done=0, o_err=0, o_err_code=0, o_line_count=0, timeout counter 0, sync flops 0.
- i_fval/i_lval pass through SYNC_STAGES flops. Edges are detected on the synchronised value against a registered copy, which adds 1 cycle of edge latency.
- States:
  - IDLE: o_fifo_rst=1. When i_start && i_sensor_ready: clear o_err/o_err_code/o_line_count, go to REQ. i_start while !i_sensor_ready is ignored; no error is raised.
  - REQ: o_fifo_rst=0, o_frame_req=1 for exactly REQ_CYCLES cycles, then o_frame_req=0. Timeout counter clears, then go to WAIT_FV.
  - WAIT_FV: wait for FVAL rising edge, then go to FRAME.
  - FRAME: each LVAL rising edge increments o_line_count, saturating at all-ones. On FVAL falling edge, go to DONE if o_line_count==EXPECTED_LINES, else go to ERR with code 2.
  - DONE: o_done=1 for one cycle, then go to IDLE.
  - ERR: o_err=1, o_frame_req=0, o_fifo_rst=1. Go to IDLE on the next cycle, keeping o_err/o_err_code sticky.
- o_busy=1 in REQ, WAIT_FV and FRAME.
- Timeout counter runs in WAIT_FV and FRAME. Reaching TIMEOUT_CYCLES-1 sends the block to ERR with code 1.
- i_fifo_full in FRAME sends the block to ERR with code 3. Priority order: overflow > timeout > line mismatch.
- LVAL edge and FVAL falling edge in the same cycle: the line is counted first, then the comparison uses the incremented value.
- FVAL already high on entry to WAIT_FV: no rising edge occurs, so the block waits; a partial frame is never captured.
- i_abort in any non-IDLE state: go to IDLE next cycle, o_frame_req=0, no o_done, no error.
- i_start while busy: ignored.
- i_start and i_abort in the same IDLE cycle: i_abort wins, so the block stays in IDLE.
- o_line_count holds its value after DONE/ERR until the next accepted start.

Decomposition:
- Shared package cmv300_pkg holds:
  - state encoding localparams (IDLE, REQ, WAIT_FV, FRAME, DONE, ERR);
  - error code constants (ERR_NONE, ERR_TIMEOUT, ERR_LINES, ERR_OVF);
  - CMV300 geometry constants (488 lines, 648 pixels).
- One sub-module, cdc_sync_edge: a parameterised N-stage synchroniser with registered rise/fall pulse outputs. It is instantiated twice, once for FVAL and once for LVAL.

Test Plan:
- Reset, then start with ready=1; model drives FVAL high, 488 LVAL pulses, FVAL low -> o_frame_req high 4 cycles, o_done single pulse ~3 cycles after FVAL fall, o_line_count=488, o_err=0.
- Start with sensor silent (FVAL never rises), TIMEOUT_CYCLES=1000 -> o_err=1, o_err_code=1 exactly 1000 cycles after REQ ends, o_fifo_rst=1.
- Frame with 487 LVAL pulses -> o_err_code=2, o_line_count=487, no o_done. A following clean start clears o_err and completes with 488.
- Assert i_fifo_full at line 100 -> o_err_code=3, o_line_count=100, immediate return to IDLE.
- i_abort mid-FRAME at line 50, plus i_start while busy -> IDLE next cycle, no o_done/o_err, second start ignored. i_start with ready=0 -> no o_frame_req.
- Assert i_rst asynchronously mid-REQ -> o_frame_req drops without waiting for a clock edge; all outputs reach their reset values.
